// File: rtl/oled_framebuffer.sv
// 128x64 monochrome framebuffer in SSD1309 page layout: pixel writes, buffer clears, column and horizontal reads.
// Optional macro FB_INIT_PATTERN_EN: the post-reset fill writes a checkerboard instead of zeros.
module oled_framebuffer #(
    parameter int DISPLAY_WIDTH  = 128,
    parameter int DISPLAY_HEIGHT = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fb_re,
    input  logic [7:0] fb_r_xpos,
    input  logic [7:0] fb_r_ypos,
    input  logic       fb_r_mode,
    output logic [7:0] fb_dout,
    output logic       fb_data_valid,
    output logic       fb_busy,
    input  logic       fb_we,
    input  logic [7:0] fb_w_xpos,
    input  logic [7:0] fb_w_ypos,
    input  logic       fb_w_pixel,
    input  logic       fb_clr,
    output logic       fb_w_ack
);
    localparam int PAGES = DISPLAY_HEIGHT / 8;
    localparam int DEPTH = PAGES * DISPLAY_WIDTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DISPLAY_WIDTH);
    localparam int PW    = $clog2(PAGES);
    localparam logic [8:0]    W_LIM     = 9'(DISPLAY_WIDTH);
    localparam logic [8:0]    H_LIM     = 9'(DISPLAY_HEIGHT);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_CLEAR,
        S_WR_READ,
        S_WR_WAIT,
        S_WR_MODIFY,
        S_RD_COL,
        S_RD_COL_WAIT,
        S_RD_H,
        S_RD_HOLD
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_cnt;
    logic [7:0]      r_dout;
    logic            r_valid;
    logic            r_ack;
    logic [6:0]      r_shift;
    logic [7:0]      r_x;
    logic [7:0]      r_y;
    logic            r_pix;
    logic [7:0]      r_ram_q;
    logic [7:0]      r_mem [0:DEPTH-1];

    logic            w_idle;
    logic            w_acc_clr;
    logic            w_acc_we;
    logic            w_acc_re;
    logic            w_w_oor;
    logic            w_oor;
    logic [8:0]      w_hcol;
    logic [8:0]      w_prev_col;
    logic            w_hbit;
    logic            w_last_h;
    logic [7:0]      w_init_byte;
    logic [7:0]      w_mod_byte;
    logic            w_ram_we;
    logic [AW-1:0]   w_ram_addr;
    logic [7:0]      w_ram_wdata;

`ifdef FB_INIT_PATTERN_EN
    assign w_init_byte = r_cnt[0] ? 8'hAA : 8'h55;
`else
    assign w_init_byte = 8'h00;
`endif

    // Strict priority clr > we > re; the ack cycle blocks re-acceptance of a still-held write/clear.
    assign w_idle     = (r_state == S_IDLE);
    assign w_acc_clr  = w_idle && fb_clr && !r_ack;
    assign w_acc_we   = w_idle && fb_we && !fb_clr && !r_ack;
    assign w_acc_re   = w_idle && fb_re && !fb_clr && !fb_we;
    assign w_w_oor    = ({1'b0, fb_w_xpos} >= W_LIM) || ({1'b0, fb_w_ypos} >= H_LIM);
    assign w_oor      = ({1'b0, r_x} >= W_LIM) || ({1'b0, r_y} >= H_LIM);

    // r_ram_q holds the column fetched on the previous edge, i.e. one behind the issue column.
    assign w_hcol     = {1'b0, r_x} + {5'b0, r_cnt[3:0]};
    assign w_prev_col = w_hcol - 9'd1;
    assign w_hbit     = !w_oor && (w_prev_col < W_LIM) && r_ram_q[r_y[2:0]];
    assign w_last_h   = (r_cnt[3:0] == 4'd8);
    assign w_mod_byte = (r_ram_q & ~(8'h01 << r_y[2:0])) | ({7'b0, r_pix} << r_y[2:0]);

    assign fb_dout       = r_dout;
    assign fb_data_valid = r_valid;
    assign fb_w_ack      = r_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT, S_CLEAR: if (r_cnt == LAST_ADDR) w_next = S_IDLE;
            S_IDLE: begin
                if (w_acc_clr)                 w_next = S_CLEAR;
                else if (w_acc_we && !w_w_oor) w_next = S_WR_READ;
                else if (w_acc_re)             w_next = fb_r_mode ? S_RD_COL : S_RD_H;
            end
            S_WR_READ:     w_next = S_WR_WAIT;
            S_WR_WAIT:     w_next = S_WR_MODIFY;
            S_WR_MODIFY:   w_next = S_IDLE;
            S_RD_COL:      w_next = S_RD_COL_WAIT;
            S_RD_COL_WAIT: w_next = S_RD_HOLD;
            S_RD_H:        if (w_last_h) w_next = S_RD_HOLD;
            S_RD_HOLD:     if (!fb_re) w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_comb begin
        fb_busy     = (r_state != S_IDLE);
        w_ram_we    = 1'b0;
        w_ram_addr  = {r_y[PW+2:3], r_x[CW-1:0]};
        w_ram_wdata = 8'h00;
        case (r_state)
            S_INIT: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_cnt;
                w_ram_wdata = w_init_byte;
            end
            S_CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_cnt;
            end
            S_WR_MODIFY: begin
                w_ram_we    = 1'b1;
                w_ram_wdata = w_mod_byte;
            end
            S_RD_H:  w_ram_addr = {r_y[PW+2:3], w_hcol[CW-1:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_dout  <= 8'h00;
            r_valid <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= w_acc_clr || w_acc_we;
            case (r_state)
                S_INIT, S_CLEAR: r_cnt <= (r_cnt == LAST_ADDR) ? '0 : r_cnt + AW'(1);
                S_RD_H: begin
                    r_cnt <= w_last_h ? '0 : r_cnt + AW'(1);
                    if (w_last_h) begin
                        r_dout  <= {r_shift, w_hbit};
                        r_valid <= 1'b1;
                    end
                end
                S_RD_COL_WAIT: begin
                    r_dout  <= w_oor ? 8'h00 : r_ram_q;
                    r_valid <= 1'b1;
                end
                S_RD_HOLD: if (!fb_re) r_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc_we) begin
            r_x   <= fb_w_xpos;
            r_y   <= fb_w_ypos;
            r_pix <= fb_w_pixel;
        end else if (w_acc_re) begin
            r_x   <= fb_r_xpos;
            r_y   <= fb_r_ypos;
        end
        if (r_state == S_RD_H) r_shift <= {r_shift[5:0], w_hbit};
    end

    // Single-port synchronous RAM, read-before-write on the shared address.
    always_ff @(posedge clk) begin
        if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
        r_ram_q <= r_mem[w_ram_addr];
    end

endmodule

// File: tb/tb_oled_framebuffer.sv
// Directed bench for oled_framebuffer: a vector table of writes/reads plus hand-written
// sequences for post-reset fill, clear/write arbitration, valid hold, early fb_re drop and async reset.
module tb_oled_framebuffer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       fb_re = 1'b0;
    logic [7:0] fb_r_xpos = 8'd0;
    logic [7:0] fb_r_ypos = 8'd0;
    logic       fb_r_mode = 1'b0;
    logic [7:0] fb_dout;
    logic       fb_data_valid;
    logic       fb_busy;
    logic       fb_we = 1'b0;
    logic [7:0] fb_w_xpos = 8'd0;
    logic [7:0] fb_w_ypos = 8'd0;
    logic       fb_w_pixel = 1'b0;
    logic       fb_clr = 1'b0;
    logic       fb_w_ack;

    int n_cmp = 0;
    int n_err = 0;

    oled_framebuffer dut (
        .clk(clk), .reset_n(reset_n),
        .fb_re(fb_re), .fb_r_xpos(fb_r_xpos), .fb_r_ypos(fb_r_ypos), .fb_r_mode(fb_r_mode),
        .fb_dout(fb_dout), .fb_data_valid(fb_data_valid), .fb_busy(fb_busy),
        .fb_we(fb_we), .fb_w_xpos(fb_w_xpos), .fb_w_ypos(fb_w_ypos), .fb_w_pixel(fb_w_pixel),
        .fb_clr(fb_clr), .fb_w_ack(fb_w_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;   // 0 = write, 1 = column read, 2 = horizontal read
        int x;
        int y;
        int v;    // pixel value for writes
        int exp;  // busy cycles for writes, read byte for reads
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic int init_byte(input int x);
`ifdef FB_INIT_PATTERN_EN
        return (x % 2 != 0) ? 32'hAA : 32'h55;
`else
        return (x < 0) ? 1 : 0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (fb_busy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (fb_busy) check({name, " idle timeout"}, 1, 0);
    endtask

    task automatic do_read(input logic mode, input int x, input int y, input int exp, input string name);
        int k;
        @(negedge clk);
        fb_r_mode = mode;
        fb_r_xpos = 8'(x);
        fb_r_ypos = 8'(y);
        fb_re     = 1'b1;
        @(posedge clk); #1;
        k = 0;
        while (!fb_data_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, " latency"}, k, mode ? 2 : 9);
        check({name, " data"}, int'(fb_dout), exp);
        @(negedge clk);
        fb_re = 1'b0;
        @(posedge clk); #1;
        check({name, " valid drop"}, int'(fb_data_valid), 0);
    endtask

    task automatic do_write(input int x, input int y, input logic pix, input int exp_busy, input string name);
        int k;
        int nb;
        @(negedge clk);
        fb_w_xpos  = 8'(x);
        fb_w_ypos  = 8'(y);
        fb_w_pixel = pix;
        fb_we      = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!fb_w_ack && k < 20);
        check({name, " ack"}, int'(fb_w_ack), 1);
        nb = fb_busy ? 1 : 0;
        @(negedge clk);
        fb_we = 1'b0;
        @(posedge clk); #1;
        check({name, " ack pulse"}, int'(fb_w_ack), 0);
        while (fb_busy && nb < 2000) begin
            nb++;
            @(posedge clk); #1;
        end
        check({name, " busy cycles"}, nb, exp_busy);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int nv;
        int vdat;

        vecs[0]  = '{0,   5, 10, 1, 3};
        vecs[1]  = '{1,   5,  8, 0, 'h04};
        vecs[2]  = '{0,   0,  3, 1, 3};
        vecs[3]  = '{0,   2,  3, 1, 3};
        vecs[4]  = '{0,   7,  3, 1, 3};
        vecs[5]  = '{2,   0,  3, 0, 'hA1};
        vecs[6]  = '{0, 127,  3, 1, 3};
        vecs[7]  = '{2, 124,  3, 0, 'h10};
        vecs[8]  = '{2, 126,  3, 0, 'h40};
        vecs[9]  = '{0,   5, 10, 0, 3};
        vecs[10] = '{0,   5,  9, 1, 3};
        vecs[11] = '{1,   5, 15, 0, 'h02};
        vecs[12] = '{1,   0,  0, 0, 'h08};
        vecs[13] = '{1,   7,  5, 0, 'h08};
        vecs[14] = '{0, 200, 70, 1, 0};
        vecs[15] = '{1,  72,  0, 0, 'h00};
        vecs[16] = '{1, 130,  0, 0, 'h00};
        vecs[17] = '{2,   0, 67, 0, 'h00};
        vecs[18] = '{1,   0, 67, 0, 'h00};
        vecs[19] = '{0,  63, 63, 1, 3};
        vecs[20] = '{1,  63, 56, 0, 'h80};
        vecs[21] = '{2,  60, 63, 0, 'h10};
        vecs[22] = '{1,  10, 16, 0, 'h10};
        vecs[23] = '{1,   1,  0, 0, 'h00};
        vecs[24] = '{2,   8,  2, 0, 'h00};

        // Reset values, then post-reset fill with a column read already requested
        fb_re = 1'b1; fb_r_mode = 1'b1; fb_r_xpos = 8'd0; fb_r_ypos = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset dout", int'(fb_dout), 0);
        check("reset valid", int'(fb_data_valid), 0);
        check("reset busy", int'(fb_busy), 1);
        check("reset ack", int'(fb_w_ack), 0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (fb_busy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("init busy edges", n, 1024);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!fb_data_valid && k < 20);
        check("init read edges", k, 3);
        check("init read data", int'(fb_dout), init_byte(0));
        @(negedge clk);
        fb_re = 1'b0;
        @(posedge clk); #1;
        check("init read drop", int'(fb_data_valid), 0);

        // Pixel to be wiped by the clear below
        do_write(1, 0, 1'b1, 3, "pre-clear write");

        // Clear and write requested together: clear first, write after the full clear
        @(negedge clk);
        fb_w_xpos = 8'd10; fb_w_ypos = 8'd20; fb_w_pixel = 1'b1;
        fb_clr = 1'b1;
        fb_we  = 1'b1;
        @(posedge clk); #1;
        check("clr ack", int'(fb_w_ack), 1);
        check("clr busy", int'(fb_busy), 1);
        @(negedge clk);
        fb_clr = 1'b0;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!fb_w_ack && k < 3000);
        check("clr-then-we ack edges", k, 1025);
        @(negedge clk);
        fb_we = 1'b0;
        @(posedge clk); #1;
        wait_idle("clr-then-we");

        for (int i = 0; i < NV; i++) begin
            case (vecs[i].op)
                0:       do_write(vecs[i].x, vecs[i].y, vecs[i].v != 0, vecs[i].exp, $sformatf("vec%0d", i));
                1:       do_read(1'b1, vecs[i].x, vecs[i].y, vecs[i].exp, $sformatf("vec%0d", i));
                default: do_read(1'b0, vecs[i].x, vecs[i].y, vecs[i].exp, $sformatf("vec%0d", i));
            endcase
        end

        // Valid held for 20 cycles while the reader changes coordinates
        @(negedge clk);
        fb_r_mode = 1'b1; fb_r_xpos = 8'd5; fb_r_ypos = 8'd8; fb_re = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!fb_data_valid && k < 20);
        check("hold latency", k, 3);
        @(negedge clk);
        fb_r_xpos = 8'd0; fb_r_mode = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold cycle %0d", c), {23'd0, fb_data_valid, fb_dout}, 'h102);
        end
        @(negedge clk);
        fb_re = 1'b0;
        @(posedge clk); #1;
        check("hold release valid", int'(fb_data_valid), 0);
        check("hold release busy", int'(fb_busy), 0);

        // fb_re dropped right after acceptance: one-cycle valid pulse, then idle
        @(negedge clk);
        fb_r_mode = 1'b0; fb_r_xpos = 8'd0; fb_r_ypos = 8'd3; fb_re = 1'b1;
        @(negedge clk);
        fb_re = 1'b0;
        nv = 0;
        vdat = -1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (fb_data_valid) begin
                nv++;
                vdat = int'(fb_dout);
            end
        end
        check("early drop valid cycles", nv, 1);
        check("early drop data", vdat, 'hA1);
        check("early drop busy", int'(fb_busy), 0);

        // Asynchronous reset in the middle of a horizontal read
        @(negedge clk);
        fb_r_mode = 1'b0; fb_r_xpos = 8'd0; fb_r_ypos = 8'd3; fb_re = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset valid", int'(fb_data_valid), 0);
        check("async reset busy", int'(fb_busy), 1);
        check("async reset dout", int'(fb_dout), 0);
        @(negedge clk);
        fb_re = 1'b0;
        reset_n = 1'b1;
        n = 0;
        while (fb_busy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("re-init busy edges", n, 1024);
        do_read(1'b1, 5, 8, init_byte(5), "re-init col5");
        do_read(1'b1, 0, 0, init_byte(0), "re-init col0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/oled_framebuffer.md
Name: oled_framebuffer

Overview:
- Single-port 128x64 monochrome pixel store (1024 bytes, SSD1309 page layout) feeding the OLED SPI driver's framebuffer read interface.
- Accepts pixel set/clear writes and whole-buffer clears from pixel-generation logic.
- Serves two read modes: column reads (one page byte, direct SSD1309 format) and horizontal reads (8 pixels across a row, assembled from 8 RAM reads).
- Clears itself after every reset.

Parameters:
- DISPLAY_WIDTH, 128, pixel columns (power of two).
- DISPLAY_HEIGHT, 64, pixel rows (multiple of 8); pages = DISPLAY_HEIGHT/8.

Ports:
- clk  in  1  system clock, 27 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- fb_re  in  1  read request level, held by reader until fb_data_valid, then dropped.
- fb_r_xpos  in  8  read column.
- fb_r_ypos  in  8  read row.
- fb_r_mode  in  1  0 = horizontal read, 1 = column read.
- fb_dout  out  8  read data.
- fb_data_valid  out  1  fb_dout valid; held until fb_re is low.
- fb_busy  out  1  high whenever state is not IDLE.
- fb_we  in  1  pixel write request level, held until fb_w_ack.
- fb_w_xpos  in  8  write column.
- fb_w_ypos  in  8  write row.
- fb_w_pixel  in  1  pixel value to write.
- fb_clr  in  1  clear request level, held until fb_w_ack.
- fb_w_ack  out  1  one-cycle pulse when fb_we or fb_clr is accepted.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Async assert forces state INIT_CLEAR, clear counter 0, and fb_dout=0, fb_data_valid=0, fb_busy=1, fb_w_ack=0. RAM itself is not reset.
- Any operation in flight when reset asserts is abandoned, and the post-reset clear restarts from address 0.
- Storage: byte address = page*DISPLAY_WIDTH + column, with page = y[5:3]. Bit y[2:0] within the byte; bit 0 is the top row of the page. Synchronous-read RAM, 1-cycle read latency (BSRAM inferable).
- INIT_CLEAR: writes 0x00 to addresses 0..1023, one per cycle (1024 cycles), then goes to IDLE. No ack is pulsed.
- IDLE: fb_busy=0. Requests are arbitrated on each edge with priority fb_clr > fb_we > fb_re. Exactly one is accepted per edge.
- fb_clr accepted: fb_w_ack pulses, state goes to CLEAR (1024 zero writes), then IDLE.
- fb_we accepted: fb_w_ack pulses.
  - Out-of-range coordinates (x >= 128 or y >= 64): acked, RAM not modified, stays in IDLE.
  - Otherwise: WR_READ (issue byte read), WR_WAIT, WR_MODIFY (write byte with bit y[2:0] replaced by fb_w_pixel), then IDLE. 3 busy cycles.
- fb_re accepted, column mode (fb_r_mode=1):
  - Returns the byte at column x, page y[5:3]; y[2:0] is ignored.
  - fb_data_valid rises at the 2nd rising edge after the accepting edge. fb_dout is stable while valid.
- fb_re accepted, horizontal mode (fb_r_mode=0):
  - Issues 8 reads for columns x..x+7 on consecutive cycles and extracts bit y[2:0] of each.
  - fb_dout[7] = column x (leftmost), fb_dout[0] = column x+7.
  - Columns >= 128 contribute 0; there is no wrap.
  - fb_data_valid rises at the 9th rising edge after acceptance.
- Out-of-range reads (x >= 128 or y >= 64): fb_dout=0x00 with valid at the normal latency for the mode.
- RD_HOLD: fb_dout/fb_data_valid are held while fb_re=1. When fb_re is sampled 0, valid is cleared on that edge and state returns to IDLE. A new read can be accepted no earlier than the following edge.
- fb_re dropped before valid: the read completes internally. Valid pulses for at most one cycle, then the block returns to IDLE.
- Mode and coordinates are captured at acceptance; later changes are ignored until the next acceptance.
- Requests arriving while busy wait (level-held) until IDLE.

Optional Feature:
- Macro: FB_INIT_PATTERN_EN.
- Defined: INIT_CLEAR writes a checkerboard, byte = 0x55 for even columns and 0xAA for odd columns, so a display test needs no pixel writer.
- fb_clr still writes zeros.
- Undefined: INIT_CLEAR writes zeros.

Test Plan:
- Release reset_n, hold fb_re=1 in column mode at x=0, y=0 -> fb_busy high for 1024 cycles; after that, fb_dout=0x00 with valid 2 edges after acceptance (0x55 with FB_INIT_PATTERN_EN).
- Write pixel (5,10)=1, then column read x=5, y=8 -> fb_w_ack single pulse, fb_busy high 3 cycles, fb_dout=0x04.
- Write pixels (0,3),(2,3),(7,3)=1, then horizontal read x=0, y=3 -> fb_dout=0xA1, valid 9 edges after acceptance. Horizontal read x=124, y=3 after writing (127,3)=1 -> fb_dout=0x10.
- Assert fb_clr and fb_we in the same IDLE cycle -> clear is acked first; the write is acked after 1024 busy cycles and persists afterwards.
- Hold valid for 20 cycles, then drop fb_re -> valid falls on the edge sampling fb_re=0. Write to (200,70) -> acked, no RAM change. Read x=130 -> 0x00.
- Assert reset_n low mid-horizontal-read -> valid=0 and busy=1 immediately (async); after release, the full 1024-cycle clear runs.
